// File: rtl/kf8237_dma_peripheral.sv
// Device-side 8237 DMA requester: DREQ/DACK/strobe handshake around a byte FIFO, with sticky EOP tracking.
// Optional KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN keeps DREQ high across back-to-back transfers.
module kf8237_dma_peripheral #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            direction_to_memory,
  input  logic                            flush,
  input  logic [7:0]                      dev_wdata,
  input  logic                            dev_wvalid,
  output logic                            dev_wready,
  output logic [7:0]                      dev_rdata,
  output logic                            dev_rvalid,
  input  logic                            dev_rready,
  output logic                            dma_request,
  input  logic                            dma_acknowledge,
  input  logic                            io_read_n,
  input  logic                            io_write_n,
  input  logic                            end_of_process_n,
  input  logic [7:0]                      data_bus_in,
  output logic [7:0]                      data_bus_out,
  output logic                            data_bus_out_enable,
  output logic                            terminal_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, REQUEST, ACKED, STROBE, DONE} state_t;

  state_t          state, nxt;
  logic            dir_q, en_q, tc_pend, dreq;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_n;
  logic [7:0]      bus_q, samp_q;

  logic strobe, full, empty, cond, cond_n;
  logic commit, abandon, latch_head, tc_hit;
  logic bus_push, bus_pop, dev_push, dev_pop, push, pop;
  logic [7:0] push_data;
  logic tc_d, tc_pend_d, dreq_d;

  assign strobe     = dir_q ? ~io_read_n : ~io_write_n;
  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign cond       = enable & ~terminal_count & ~flush & (direction_to_memory ? ~empty : ~full);
  assign dev_wready = ~full & direction_to_memory;
  assign dev_rvalid = ~empty & ~direction_to_memory;
  assign dev_rdata  = mem[rptr];
  assign tc_hit     = ((state == ACKED) || (state == STROBE)) & ~end_of_process_n;

  assign data_bus_out_enable = (state == STROBE) & dir_q & dma_acknowledge & strobe;
  assign data_bus_out        = data_bus_out_enable ? bus_q : 8'h00;
  assign dma_request         = dreq;
  assign fifo_count          = count;

  always_comb begin
    nxt        = state;
    commit     = 1'b0;
    abandon    = 1'b0;
    latch_head = 1'b0;
    case (state)
      IDLE:    if (cond) nxt = REQUEST;
      REQUEST: if (dma_acknowledge) nxt = ACKED;
               else if (!cond)      nxt = IDLE;
      ACKED: begin
        if (strobe && dma_acknowledge) begin
          nxt        = STROBE;
          latch_head = 1'b1;
        end else if (!dma_acknowledge) begin
          nxt = REQUEST;
        end
      end
      STROBE: begin
        if (!dma_acknowledge) begin
          abandon = 1'b1;
          nxt     = IDLE;
        end else if (!strobe) begin
          commit = 1'b1;
          nxt    = DONE;
        end
      end
`ifdef KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
      DONE:    nxt = cond ? REQUEST : IDLE;
`else
      DONE:    nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
    if (flush) begin
      nxt     = IDLE;
      commit  = 1'b0;
      abandon = 1'b0;
    end
  end

  // Bus side owns one end of the FIFO, device side the other, chosen by direction.
  always_comb begin
    bus_push  = commit & ~dir_q;
    bus_pop   = commit & dir_q;
    dev_push  = dev_wvalid & dev_wready;
    dev_pop   = dev_rvalid & dev_rready;
    push      = (bus_push | dev_push) & ~full & ~flush;
    pop       = (bus_pop | dev_pop) & ~empty & ~flush;
    push_data = bus_push ? samp_q : dev_wdata;
    count_n   = flush ? '0 : count + CW'(push) - CW'(pop);
  end

  always_comb begin
    tc_d      = terminal_count;
    tc_pend_d = tc_pend | tc_hit;
    if (enable && !en_q) tc_d = 1'b0;
    if (commit) begin
      tc_d      = tc_d | tc_pend | tc_hit;
      tc_pend_d = 1'b0;
    end
    if (abandon) tc_pend_d = 1'b0;
    if (flush) begin
      tc_d      = 1'b0;
      tc_pend_d = 1'b0;
    end
    cond_n = enable & ~tc_d & ~flush &
             (direction_to_memory ? (count_n != '0) : (count_n < CW'(FIFO_DEPTH)));
    dreq_d = (nxt == REQUEST) || (nxt == ACKED);
`ifdef KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
    // Hold DREQ through DONE when another transfer can follow immediately.
    if (nxt == DONE) dreq_d = cond_n;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      dir_q          <= 1'b0;
      en_q           <= 1'b0;
      tc_pend        <= 1'b0;
      terminal_count <= 1'b0;
      dreq           <= 1'b0;
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      bus_q          <= 8'h00;
      samp_q         <= 8'h00;
    end else begin
      state          <= nxt;
      en_q           <= enable;
      tc_pend        <= tc_pend_d;
      terminal_count <= tc_d;
      dreq           <= dreq_d;
      count          <= count_n;
      if (state == IDLE && nxt != IDLE) dir_q <= direction_to_memory;
      if (latch_head) bus_q <= mem[rptr];
      if ((state == ACKED || state == STROBE) && strobe && dma_acknowledge && !dir_q)
        samp_q <= data_bus_in;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem[wptr] <= push_data;
  end
endmodule

// File: tb/tb_kf8237_dma_peripheral.sv
// Directed bench for kf8237_dma_peripheral: both directions, EOP/TC, full FIFO, aborted cycles, flush.
module tb_kf8237_dma_peripheral;
  logic       clock = 1'b0;
  logic       reset, enable, direction_to_memory, flush;
  logic [7:0] dev_wdata, dev_rdata, data_bus_in, data_bus_out;
  logic       dev_wvalid, dev_wready, dev_rvalid, dev_rready;
  logic       dma_request, dma_acknowledge, io_read_n, io_write_n, end_of_process_n;
  logic       data_bus_out_enable, terminal_count;
  logic [3:0] fifo_count;

  int n_chk = 0;
  int n_fail = 0;

  kf8237_dma_peripheral #(.FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .direction_to_memory(direction_to_memory),
    .flush(flush), .dev_wdata(dev_wdata), .dev_wvalid(dev_wvalid), .dev_wready(dev_wready),
    .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid), .dev_rready(dev_rready),
    .dma_request(dma_request), .dma_acknowledge(dma_acknowledge), .io_read_n(io_read_n),
    .io_write_n(io_write_n), .end_of_process_n(end_of_process_n), .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out), .data_bus_out_enable(data_bus_out_enable),
    .terminal_count(terminal_count), .fifo_count(fifo_count));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_dreq(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dma_request) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    dev_wdata = d; dev_wvalid = 1'b1;
    tick();
    dev_wvalid = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  // One DACK + strobe transfer starting from REQUEST; reports bus data and DREQ in the two clocks after commit.
  task automatic bus_cycle(input logic rd, input logic [7:0] wd, input logic eop,
                           output logic [7:0] dout, output logic oe, output logic dq1, output logic dq2);
    dma_acknowledge = 1'b1;
    tick();
    if (rd) io_read_n = 1'b0;
    else begin io_write_n = 1'b0; data_bus_in = wd; end
    end_of_process_n = ~eop;
    tick();
    dout = data_bus_out; oe = data_bus_out_enable;
    io_read_n = 1'b1; io_write_n = 1'b1; end_of_process_n = 1'b1;
    tick();
    dma_acknowledge = 1'b0;
    dq1 = dma_request;
    tick();
    dq2 = dma_request;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick(); tick();
    n_chk++; if (dma_request !== 1'b0) begin n_fail++; $display("FAIL reset_dreq got %b want 0", dma_request); end
    n_chk++; if (data_bus_out_enable !== 1'b0 || data_bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus got oe=%b d=%h want 0/00", data_bus_out_enable, data_bus_out); end
    n_chk++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b want 0", terminal_count); end
    n_chk++; if (fifo_count !== 4'd0 || dev_wready !== 1'b1 || dev_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_fifo got cnt=%0d wr=%b rv=%b want 0/1/0", fifo_count, dev_wready, dev_rvalid); end
    reset = 1'b0;
  endtask

  task automatic test_dev_to_mem;
    logic [7:0] exp_d [3];
    logic [7:0] d; logic oe, q1, q2, ok;
    exp_d[0] = 8'hA5; exp_d[1] = 8'h5A; exp_d[2] = 8'hC3;
    enable = 1'b1; direction_to_memory = 1'b1;
    push_byte(8'hA5);
    n_chk++; if (dma_request !== 1'b0) begin n_fail++; $display("FAIL d2m_dreq_early got %b want 0", dma_request); end
    push_byte(8'h5A);
    n_chk++; if (dma_request !== 1'b1) begin n_fail++; $display("FAIL d2m_dreq_rise got %b want 1", dma_request); end
    push_byte(8'hC3);
    for (int i = 0; i < 3; i++) begin
      wait_dreq(ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL d2m_wait_dreq%0d timeout", i); end
      bus_cycle(1'b1, 8'h00, 1'b0, d, oe, q1, q2);
      n_chk++; if (d !== exp_d[i] || oe !== 1'b1) begin n_fail++; $display("FAIL d2m_read%0d got %h oe=%b want %h oe=1", i, d, oe, exp_d[i]); end
`ifndef KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
      n_chk++; if ({q1, q2} !== 2'b00) begin n_fail++; $display("FAIL d2m_gap%0d got %b want 00", i, {q1, q2}); end
`endif
      n_chk++; if (fifo_count !== 4'(2 - i)) begin n_fail++; $display("FAIL d2m_count%0d got %0d want %0d", i, fifo_count, 2 - i); end
    end
    tick(); tick(); tick();
    n_chk++; if (dma_request !== 1'b0) begin n_fail++; $display("FAIL d2m_empty_dreq got %b want 0", dma_request); end
  endtask

  task automatic test_mem_to_dev;
    logic [7:0] d; logic oe, q1, q2, ok;
    direction_to_memory = 1'b0;
    wait_dreq(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL m2d_dreq timeout"); end
    bus_cycle(1'b0, 8'h11, 1'b0, d, oe, q1, q2);
    n_chk++; if (oe !== 1'b0) begin n_fail++; $display("FAIL m2d_oe got %b want 0", oe); end
    n_chk++; if (fifo_count !== 4'd1 || dev_rvalid !== 1'b1 || dev_rdata !== 8'h11) begin n_fail++; $display("FAIL m2d_first got cnt=%0d rv=%b d=%h want 1/1/11", fifo_count, dev_rvalid, dev_rdata); end
    wait_dreq(ok);
    bus_cycle(1'b0, 8'h22, 1'b0, d, oe, q1, q2);
    n_chk++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL m2d_count2 got %0d want 2", fifo_count); end
    dev_rready = 1'b1;
    tick();
    n_chk++; if (fifo_count !== 4'd1 || dev_rdata !== 8'h22) begin n_fail++; $display("FAIL m2d_pop1 got cnt=%0d d=%h want 1/22", fifo_count, dev_rdata); end
    tick();
    dev_rready = 1'b0;
    n_chk++; if (fifo_count !== 4'd0 || dev_rvalid !== 1'b0) begin n_fail++; $display("FAIL m2d_pop2 got cnt=%0d rv=%b want 0/0", fifo_count, dev_rvalid); end
  endtask

  task automatic test_eop;
    logic [7:0] d; logic oe, q1, q2, ok;
    do_flush();
    direction_to_memory = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    wait_dreq(ok);
    bus_cycle(1'b1, 8'h00, 1'b0, d, oe, q1, q2);
    n_chk++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL eop_tc_early got %b want 0", terminal_count); end
    wait_dreq(ok);
    bus_cycle(1'b1, 8'h00, 1'b1, d, oe, q1, q2);
    n_chk++; if (d !== 8'h02) begin n_fail++; $display("FAIL eop_data got %h want 02", d); end
    n_chk++; if (terminal_count !== 1'b1 || fifo_count !== 4'd2) begin n_fail++; $display("FAIL eop_tc got tc=%b cnt=%0d want 1/2", terminal_count, fifo_count); end
    tick(); tick(); tick(); tick();
    n_chk++; if (dma_request !== 1'b0 || terminal_count !== 1'b1) begin n_fail++; $display("FAIL eop_hold got dreq=%b tc=%b want 0/1", dma_request, terminal_count); end
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    n_chk++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL eop_clear got %b want 0", terminal_count); end
    wait_dreq(ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL eop_rearm timeout"); end
  endtask

  task automatic test_full;
    logic [7:0] d; logic oe, q1, q2, ok;
    do_flush();
    direction_to_memory = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_dreq(ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_wait%0d timeout", i); end
      bus_cycle(1'b0, 8'(8'h30 + i), 1'b0, d, oe, q1, q2);
    end
    tick(); tick();
    n_chk++; if (fifo_count !== 4'd8 || dma_request !== 1'b0 || dev_wready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt=%0d dreq=%b wr=%b want 8/0/0", fifo_count, dma_request, dev_wready); end
    n_chk++; if (dev_rdata !== 8'h30) begin n_fail++; $display("FAIL full_head got %h want 30", dev_rdata); end
    dev_rready = 1'b1; tick(); dev_rready = 1'b0;
    tick();
    n_chk++; if (dma_request !== 1'b1 || fifo_count !== 4'd7) begin n_fail++; $display("FAIL full_rearm got dreq=%b cnt=%0d want 1/7", dma_request, fifo_count); end
  endtask

  task automatic test_abort;
    logic [7:0] d; logic oe, q1, q2, ok;
    do_flush();
    direction_to_memory = 1'b1;
    push_byte(8'h77);
    wait_dreq(ok);
    dma_acknowledge = 1'b1; tick();
    dma_acknowledge = 1'b0; tick();
    tick();
    n_chk++; if (fifo_count !== 4'd1 || dma_request !== 1'b1) begin n_fail++; $display("FAIL abort_noior got cnt=%0d dreq=%b want 1/1", fifo_count, dma_request); end
    dma_acknowledge = 1'b1; tick();
    io_read_n = 1'b0; tick();
    dma_acknowledge = 1'b0; tick();
    io_read_n = 1'b1;
    n_chk++; if (fifo_count !== 4'd1 || data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL abort_strobe got cnt=%0d oe=%b want 1/0", fifo_count, data_bus_out_enable); end
    wait_dreq(ok);
    bus_cycle(1'b1, 8'h00, 1'b0, d, oe, q1, q2);
    n_chk++; if (d !== 8'h77 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL abort_retry got %h cnt=%0d want 77/0", d, fifo_count); end
  endtask

  task automatic test_flush;
    logic ok;
    direction_to_memory = 1'b1;
    push_byte(8'h81); push_byte(8'h82); push_byte(8'h83);
    wait_dreq(ok);
    dma_acknowledge = 1'b1; tick();
    io_read_n = 1'b0; tick();
    flush = 1'b1; io_read_n = 1'b1; tick();
    flush = 1'b0; dma_acknowledge = 1'b0;
    n_chk++; if (fifo_count !== 4'd0 || dma_request !== 1'b0 || terminal_count !== 1'b0) begin n_fail++; $display("FAIL flush_state got cnt=%0d dreq=%b tc=%b want 0/0/0", fifo_count, dma_request, terminal_count); end
    tick();
    n_chk++; if (dma_request !== 1'b0 || data_bus_out_enable !== 1'b0) begin n_fail++; $display("FAIL flush_idle got dreq=%b oe=%b want 0/0", dma_request, data_bus_out_enable); end
  endtask

`ifdef KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
  task automatic test_demand;
    logic [7:0] d; logic oe, q1, q2, ok;
    do_flush();
    direction_to_memory = 1'b1;
    push_byte(8'h91); push_byte(8'h92); push_byte(8'h93);
    wait_dreq(ok);
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b1, 8'h00, 1'b0, d, oe, q1, q2);
      n_chk++; if ({q1, q2} !== 2'b11) begin n_fail++; $display("FAIL demand_hold%0d got %b want 11", i, {q1, q2}); end
    end
    bus_cycle(1'b1, 8'h00, 1'b0, d, oe, q1, q2);
    n_chk++; if (q1 !== 1'b0 || d !== 8'h93) begin n_fail++; $display("FAIL demand_last got dreq=%b d=%h want 0/93", q1, d); end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; direction_to_memory = 1'b1; flush = 1'b0;
    dev_wdata = 8'h00; dev_wvalid = 1'b0; dev_rready = 1'b0;
    dma_acknowledge = 1'b0; io_read_n = 1'b1; io_write_n = 1'b1; end_of_process_n = 1'b1;
    data_bus_in = 8'h00;
    test_reset();
    test_dev_to_mem();
    test_mem_to_dev();
    test_eop();
    test_full();
    test_abort();
    test_flush();
`ifdef KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
    test_demand();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kf8237_dma_peripheral.md
Name: kf8237_dma_peripheral

Overview:
Device-side endpoint of the 8237 DMA handshake. It raises DREQ, waits for DACK, then answers the IOR or IOW strobe the controller issues. Data is buffered in a byte FIFO between a local device interface and the DMA bus, and the EOP terminal-count indication is tracked. It sits beside a peripheral (floppy, disk, sound) on one DMA channel and lets the DMA-controller bench and system run against a realistic requester.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  channel enable; a rising edge clears terminal_count
direction_to_memory  in  1  1: device→memory (bus uses IOR); 0: memory→device (bus uses IOW)
flush  in  1  empty FIFO, clear terminal_count, return to IDLE
dev_wdata  in  8  device push data (direction_to_memory=1)
dev_wvalid  in  1  push request
dev_wready  out  1  FIFO not full and direction_to_memory=1
dev_rdata  out  8  FIFO head (direction_to_memory=0)
dev_rvalid  out  1  FIFO not empty and direction_to_memory=0
dev_rready  in  1  pop acknowledge
dma_request  out  1  DREQ, active high, registered
dma_acknowledge  in  1  DACK, active high
io_read_n  in  1  bus IOR strobe
io_write_n  in  1  bus IOW strobe
end_of_process_n  in  1  EOP from controller, active low
data_bus_in  in  8  bus data during IOW
data_bus_out  out  8  bus data during IOR; 8'h00 when not driving
data_bus_out_enable  out  1  high while this block drives the bus
terminal_count  out  1  sticky TC flag
fifo_count  out  log2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset: FIFO empty, state IDLE, and all of dma_request, data_bus_out_enable, terminal_count and data_bus_out forced to 0. Combinational outputs follow from count=0.
- Request condition (cond): enable & ~terminal_count & ~flush & (direction_to_memory ? count>0 : count<FIFO_DEPTH).
- direction_to_memory is latched on leaving IDLE. Changing it with a non-empty FIFO requires a flush first.
- Strobe: IOR when latched direction=1, IOW when latched direction=0. Active means the strobe is low.
- FSM:
  - IDLE: dma_request=0. If cond, go to REQUEST (DREQ high on the next clock).
  - REQUEST: dma_request=1. If dack=1, go to ACKED. If cond is lost before DACK, go to IDLE.
  - ACKED: dma_request=1. On strobe active with dack=1, go to STROBE and latch the FIFO head into data_bus_out. On dack=0 with no strobe, go to REQUEST; this is an aborted cycle with no transfer.
  - STROBE:
    - direction=1: data_bus_out_enable=1 while dack=1 and strobe active.
    - direction=0: data_bus_in is sampled every clock while the strobe is active.
    - end_of_process_n=0 on any clock in ACKED or STROBE sets the internal tc_pending.
    - Strobe deasserts with dack still 1: commit. direction=1 pops the FIFO; direction=0 pushes the last sampled byte. tc_pending transfers to terminal_count. Go to DONE.
    - dack drops while the strobe is still active: abandon with no push/pop, clear tc_pending, go to IDLE.
  - DONE: one clock, dma_request=0 (single-transfer mode), then IDLE.
- dma_request deasserts in the clock after the committing strobe edge and stays low at least 2 clocks (DONE + IDLE) between transfers.
- FIFO ownership:
  - direction=1: the device only pushes and the bus only pops.
  - direction=0: the bus only pushes and the device only pops.
  - A device access and a bus commit in the same clock are both honoured; count is unchanged when one push and one pop coincide.
  - Push when full and pop when empty are ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- terminal_count is sticky. While set, dma_request stays 0; the FIFO contents are kept and remain accessible on the device side. It is cleared by reset, flush, or an enable 0→1 edge.
- flush has priority over every event except reset. In the same clock it empties the FIFO, clears terminal_count and tc_pending, forces IDLE and dma_request=0, and cancels any in-flight commit.
- enable=0 mid-cycle: the block finishes an already-started STROBE, then stays in IDLE.

Optional Feature:
KF8237_DMA_PERIPHERAL_DEMAND_MODE_EN
- Defined: DONE goes directly to REQUEST when cond still holds, and dma_request stays high across back-to-back transfers. It drops only when cond fails, or in the clock after an EOP commit.
- Undefined: single-transfer behaviour as above.

Test Plan:
- dir=1; push A5, 5A, C3 → dma_request rises 2 clocks after the first push. Three DACK+IOR cycles read A5, 5A, C3 on data_bus_out with data_bus_out_enable high. DREQ is low ≥2 clocks between cycles and stays 0 once fifo_count=0.
- dir=0, empty, enable=1 → DREQ=1. Two IOW cycles with data 11, 22 → dev_rvalid=1, and the device pops 11 then 22. fifo_count goes 0→1→2→1→0.
- dir=1, 4 bytes queued; EOP low during the 2nd IOR → terminal_count=1 after the commit, DREQ stays 0, fifo_count=2. Pulse enable 0→1 → terminal_count=0 and DREQ reasserts.
- dir=0; 8 IOW cycles → fifo_count=8, DREQ=0, dev_wready=0. One device pop → DREQ=1 within 2 clocks.
- dir=1, 1 byte queued; DACK high then low with no IOR → fifo_count stays 1 and DREQ remains high. Separately, drop DACK during an active IOR → no pop.
- Assert flush mid-STROBE with 3 bytes queued → fifo_count=0, DREQ=0, no pop; the next clock is IDLE. With DEMAND_MODE_EN, 3 back-to-back IOR cycles keep DREQ high continuously.
